// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the shared coordinate type for the VGA path.
package vga_timing_pkg;

  localparam int H_VISIBLE_D = 640;
  localparam int H_FRONT_D   = 16;
  localparam int H_SYNC_D    = 96;
  localparam int H_BACK_D    = 48;
  localparam int V_VISIBLE_D = 480;
  localparam int V_FRONT_D   = 10;
  localparam int V_SYNC_D    = 2;
  localparam int V_BACK_D    = 33;

  localparam int H_TOTAL_D = H_VISIBLE_D + H_FRONT_D + H_SYNC_D + H_BACK_D;
  localparam int V_TOTAL_D = V_VISIBLE_D + V_FRONT_D + V_SYNC_D + V_BACK_D;

  // Sync regions are half-open: [START, END).
  localparam int HS_START_D = H_VISIBLE_D + H_FRONT_D;
  localparam int HS_END_D   = HS_START_D + H_SYNC_D;
  localparam int VS_START_D = V_VISIBLE_D + V_FRONT_D;
  localparam int VS_END_D   = VS_START_D + V_SYNC_D;

  typedef logic [9:0] coord_t;

  function automatic coord_t to_coord(input int v);
    return coord_t'(v);
  endfunction

endpackage

// File: rtl/sync_delay.sv
// N-stage shift register with a per-bit reset value, used to align sync/blank with mapper RGB.
// Only compiled when VGA_SYNC_ALIGN_EN is defined, since nothing else instantiates it.
`ifdef VGA_SYNC_ALIGN_EN
module sync_delay #(
  parameter int           N       = 2,
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_stage [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_stage[i] <= RST_VAL;
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < N; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign q = r_stage[N-1];

endmodule
`endif

// File: rtl/vga_timing_gen.sv
// Free-running VGA scan/sync generator on the pixel clock; all outputs registered.
// Macro VGA_SYNC_ALIGN_EN delays hs/vs/blank by two cycles to match mapper RGB latency.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE   = H_VISIBLE_D,
  parameter int H_FRONT     = H_FRONT_D,
  parameter int H_SYNC      = H_SYNC_D,
  parameter int H_BACK      = H_BACK_D,
  parameter int V_VISIBLE   = V_VISIBLE_D,
  parameter int V_FRONT     = V_FRONT_D,
  parameter int V_SYNC      = V_SYNC_D,
  parameter int V_BACK      = V_BACK_D,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   vga_clk,
  input  logic                   reset_n,
  output coord_t                 DrawX,
  output coord_t                 DrawY,
  output logic                   hs,
  output logic                   vs,
  output logic                   blank,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int     H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int     V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam coord_t H_LAST   = to_coord(H_TOTAL - 1);
  localparam coord_t V_LAST   = to_coord(V_TOTAL - 1);
  localparam coord_t H_VIS    = to_coord(H_VISIBLE);
  localparam coord_t V_VIS    = to_coord(V_VISIBLE);
  localparam coord_t HS_START = to_coord(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END   = to_coord(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_START = to_coord(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END   = to_coord(V_VISIBLE + V_FRONT + V_SYNC);

  coord_t                 r_hc;
  coord_t                 r_vc;
  logic                   r_hs;
  logic                   r_vs;
  logic                   r_blank;
  logic                   r_frame_start;
  logic [FRAME_CNT_W-1:0] r_frame_count;

  coord_t w_hc_nxt;
  coord_t w_vc_nxt;
  logic   w_h_wrap;
  logic   w_frame_wrap;
  logic   w_hs_nxt;
  logic   w_vs_nxt;
  logic   w_blank_nxt;

  // Decode from next-state counters so the registered flags line up with DrawX/DrawY.
  always_comb begin
    w_h_wrap     = (r_hc == H_LAST);
    w_frame_wrap = w_h_wrap && (r_vc == V_LAST);
    w_hc_nxt     = w_h_wrap ? '0 : r_hc + 10'd1;
    w_vc_nxt     = r_vc;
    if (w_h_wrap) w_vc_nxt = (r_vc == V_LAST) ? '0 : r_vc + 10'd1;
    w_hs_nxt     = !((w_hc_nxt >= HS_START) && (w_hc_nxt < HS_END));
    w_vs_nxt     = !((w_vc_nxt >= VS_START) && (w_vc_nxt < VS_END));
    w_blank_nxt  = (w_hc_nxt < H_VIS) && (w_vc_nxt < V_VIS);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hc          <= '0;
      r_vc          <= '0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank       <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_hc          <= w_hc_nxt;
      r_vc          <= w_vc_nxt;
      r_hs          <= w_hs_nxt;
      r_vs          <= w_vs_nxt;
      r_blank       <= w_blank_nxt;
      r_frame_start <= w_frame_wrap;
      if (w_frame_wrap) r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
    end
  end

  assign DrawX       = r_hc;
  assign DrawY       = r_vc;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

`ifdef VGA_SYNC_ALIGN_EN
  logic [2:0] w_sync_dly;

  sync_delay #(
    .N       (2),
    .W       (3),
    .RST_VAL (3'b110)
  ) u_sync_delay (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .d     ({r_hs, r_vs, r_blank}),
    .q     (w_sync_dly)
  );

  assign {hs, vs, blank} = w_sync_dly;
`else
  assign hs    = r_hs;
  assign vs    = r_vs;
  assign blank = r_blank;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a default-timing instance and a shrunken-timing instance (fast full frames)
// are compared every cycle against an arithmetic model indexed by clock edges since reset release.
module tb_vga_timing_gen;

  localparam int SH_V = 12, SH_F = 2, SH_S = 3, SH_B = 3;
  localparam int SV_V = 4,  SV_F = 1, SV_S = 1, SV_B = 2;
  localparam int S_FRAME = (SH_V + SH_F + SH_S + SH_B) * (SV_V + SV_F + SV_S + SV_B);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [9:0] d_x, d_y, s_x, s_y;
  logic       d_hs, d_vs, d_blank, d_fs, s_hs, s_vs, s_blank, s_fs;
  logic [7:0] d_fc, s_fc;

  vga_timing_gen u_def (
    .vga_clk(clk), .reset_n(rst_n), .DrawX(d_x), .DrawY(d_y), .hs(d_hs), .vs(d_vs),
    .blank(d_blank), .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(SH_V), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
    .V_VISIBLE(SV_V), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B), .FRAME_CNT_W(8)
  ) u_sm (
    .vga_clk(clk), .reset_n(rst_n), .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs),
    .blank(s_blank), .frame_start(s_fs), .frame_count(s_fc)
  );

  obs_t q_def[$];
  obs_t q_sm[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  longint e_cnt  = 0;

  // Undelayed behaviour after e clock edges since reset release (e==0: still in reset state).
  function automatic obs_t ref_raw(input longint e, input int hv, hf, hsw, hb, vv, vf, vsw, vb);
    obs_t   o;
    longint ht, vt, x, y;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    if (e == 0) begin
      o.x = '0; o.y = '0; o.hs = 1'b1; o.vs = 1'b1; o.blank = 1'b0; o.fs = 1'b0; o.fc = '0;
      return o;
    end
    x = e % ht;
    y = (e / ht) % vt;
    o.x     = 10'(x);
    o.y     = 10'(y);
    o.hs    = !(x >= hv + hf && x < hv + hf + hsw);
    o.vs    = !(y >= vv + vf && y < vv + vf + vsw);
    o.blank = (x < hv) && (y < vv);
    o.fs    = (e % (ht * vt)) == 0;
    o.fc    = 8'((e / (ht * vt)) % 256);
    return o;
  endfunction

  function automatic obs_t ref_out(input longint e, input int hv, hf, hsw, hb, vv, vf, vsw, vb);
    obs_t o;
    o = ref_raw(e, hv, hf, hsw, hb, vv, vf, vsw, vb);
`ifdef VGA_SYNC_ALIGN_EN
    begin
      obs_t d;
      d = ref_raw((e < 2) ? 0 : e - 2, hv, hf, hsw, hb, vv, vf, vsw, vb);
      o.hs = d.hs; o.vs = d.vs; o.blank = d.blank;
    end
`endif
    return o;
  endfunction

  function automatic obs_t exp_def(input longint e);
    return ref_out(e, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic obs_t exp_sm(input longint e);
    return ref_out(e, SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B);
  endfunction

  function automatic obs_t act_def();
    obs_t a;
    a.x = d_x; a.y = d_y; a.hs = d_hs; a.vs = d_vs; a.blank = d_blank; a.fs = d_fs; a.fc = d_fc;
    return a;
  endfunction

  function automatic obs_t act_sm();
    obs_t a;
    a.x = s_x; a.y = s_y; a.hs = s_hs; a.vs = s_vs; a.blank = s_blank; a.fs = s_fs; a.fc = s_fc;
    return a;
  endfunction

  task automatic check(input string nm, input obs_t exp, input obs_t act);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got x=%0d y=%0d hs=%b vs=%b blank=%b fs=%b fc=%0d, want x=%0d y=%0d hs=%b vs=%b blank=%b fs=%b fc=%0d",
                  nm, $time, act.x, act.y, act.hs, act.vs, act.blank, act.fs, act.fc,
                  exp.x, exp.y, exp.hs, exp.vs, exp.blank, exp.fs, exp.fc);
  endtask

  // Expected-response producer: one entry per clock edge per instance.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) e_cnt = 0;
      else        e_cnt = e_cnt + 1;
      q_def.push_back(exp_def(e_cnt));
      q_sm.push_back(exp_sm(e_cnt));
    end
  end

  // Monitor: the DUT presents a new output every cycle; sample on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q_def.size() > 0) check("def_cycle", q_def.pop_front(), act_def());
      if (q_sm.size() > 0)  check("sm_cycle", q_sm.pop_front(), act_sm());
    end
  end

  task automatic reset_pulse(input string nm);
    #1 rst_n = 1'b0;
    #1;
    check({nm, "_def_async"}, exp_def(0), act_def());
    check({nm, "_sm_async"}, exp_sm(0), act_sm());
    repeat ($urandom_range(1, 3)) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_def(input int x);
    int n = 0;
    while (d_x !== 10'(x) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      n_checks++;
      $display("FAIL wait_def: DrawX=%0d, required %0d within 2000 cycles", d_x, x);
    end
  endtask

  task automatic wait_sm(input int x, input int y);
    int n = 0;
    while ((s_x !== 10'(x) || s_y !== 10'(y)) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      n_checks++;
      $display("FAIL wait_sm: (%0d,%0d), required (%0d,%0d) within 2000 cycles", s_x, s_y, x, y);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (1700) @(negedge clk);
    wait_def(700);
    reset_pulse("rst_def_hsync");
    repeat (200) @(negedge clk);
    wait_sm(SH_V + SH_F + 1, SV_V + SV_F);
    reset_pulse("rst_sm_sync");
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(20, 600)) @(negedge clk);
      reset_pulse("rst_random");
    end
    repeat (256 * S_FRAME + 300) @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
